// File: rtl/round_sequencer.sv
// round_sequencer: memory-game round controller that grows a symbol pattern, plays it out and checks player input.
// Optional input timeout is compiled in with ROUND_SEQ_TIMEOUT_EN.
module round_sequencer #(
    parameter int MAX_LEN       = 16,
    parameter int LIVES         = 3,
    parameter int TICK_DIV      = 25000000,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic       clock_i,
    input  logic       reset_ni,
    input  logic       start_i,
    input  logic [2:0] rand_sym_i,
    input  logic       sym_valid_i,
    input  logic [2:0] sym_in_i,
    output logic [2:0] display_out_o,
    output logic       display_active_o,
    output logic [7:0] score_o,
    output logic [3:0] lives_o,
    output logic       game_over_o,
    output logic       win_o,
    output logic       busy_o
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_LEN);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_START_WAIT, S_APPEND, S_SHOW, S_GAP, S_INPUT, S_SCORE, S_MISS, S_OVER, S_WIN
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [7:0]      score_q, score_d;
    logic [3:0]      lives_q, lives_d;
    logic [2:0]      pattern_q [MAX_LEN];
    logic            wr_en;
    logic [2:0]      cur_sym;
    logic            tick_wrap;
    logic            last;
    logic            unused_rand;

    // Only the two low generator bits pick one of the four symbols.
    assign unused_rand = rand_sym_i[2];

`ifdef ROUND_SEQ_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_TICKS + 1);
    logic [SW-1:0]   step_q, step_d;
`else
    logic            unused_timeout;
    assign unused_timeout = (TIMEOUT_TICKS > 0);
`endif

    assign cur_sym   = pattern_q[idx_q];
    assign tick_wrap = tick_q == TW'(TICK_DIV - 1);
    assign last      = (LW'(idx_q) + 1'b1) == len_q;

    assign display_out_o    = (state_q == S_SHOW) ? cur_sym : 3'd0;
    assign display_active_o = (state_q == S_SHOW) || (state_q == S_GAP);
    assign score_o          = score_q;
    assign lives_o          = lives_q;
    assign game_over_o      = (state_q == S_OVER) || (state_q == S_WIN);
    assign win_o            = state_q == S_WIN;
    assign busy_o           = !((state_q == S_IDLE) || (state_q == S_OVER) || (state_q == S_WIN));

    // Pattern storage; contents survive reset since len gates every read.
    always_ff @(posedge clock_i) begin
        if (wr_en) pattern_q[len_q[IW-1:0]] <= {1'b0, rand_sym_i[1:0]} + 3'd1;
    end

    // Control and datapath registers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            tick_q  <= '0;
            score_q <= '0;
            lives_q <= 4'(LIVES);
`ifdef ROUND_SEQ_TIMEOUT_EN
            step_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            score_q <= score_d;
            lives_q <= lives_d;
`ifdef ROUND_SEQ_TIMEOUT_EN
            step_q  <= step_d;
`endif
        end
    end

    // Next-state logic: playback pacing, input matching, score and lives bookkeeping.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        tick_d  = tick_q + 1'b1;
        score_d = score_q;
        lives_d = lives_q;
        wr_en   = 1'b0;
`ifdef ROUND_SEQ_TIMEOUT_EN
        step_d  = step_q;
`endif
        case (state_q)
            S_IDLE, S_OVER, S_WIN: begin
                if (start_i) begin
                    state_d = S_START_WAIT;
                    score_d = '0;
                    len_d   = '0;
                    lives_d = 4'(LIVES);
                end
            end
            S_START_WAIT: begin
                if (!start_i) state_d = S_APPEND;
            end
            S_APPEND: begin
                wr_en   = 1'b1;
                len_d   = len_q + 1'b1;
                idx_d   = '0;
                tick_d  = '0;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                if (tick_wrap) begin
                    tick_d  = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (tick_wrap) begin
                    tick_d = '0;
                    if (last) begin
                        idx_d   = '0;
                        state_d = S_INPUT;
`ifdef ROUND_SEQ_TIMEOUT_EN
                        step_d  = '0;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_SHOW;
                    end
                end
            end
            S_INPUT: begin
`ifdef ROUND_SEQ_TIMEOUT_EN
                tick_d = tick_wrap ? '0 : tick_q + 1'b1;
                step_d = tick_wrap ? step_q + 1'b1 : step_q;
`endif
                if (sym_valid_i && sym_in_i != 3'd0) begin
                    if (sym_in_i == cur_sym) begin
                        state_d = last ? S_SCORE : S_INPUT;
                        idx_d   = last ? idx_q : idx_q + 1'b1;
`ifdef ROUND_SEQ_TIMEOUT_EN
                        tick_d  = '0;
                        step_d  = '0;
`endif
                    end else begin
                        state_d = S_MISS;
                    end
                end
`ifdef ROUND_SEQ_TIMEOUT_EN
                else if (tick_wrap && step_q == SW'(TIMEOUT_TICKS - 1)) begin
                    state_d = S_MISS;
                end
`endif
            end
            S_SCORE: begin
                score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                state_d = (len_q == LW'(MAX_LEN)) ? S_WIN : S_APPEND;
            end
            S_MISS: begin
                if (lives_q == 4'd1) begin
                    lives_d = '0;
                    state_d = S_OVER;
                end else begin
                    lives_d = lives_q - 4'd1;
                    idx_d   = '0;
                    tick_d  = '0;
                    state_d = S_SHOW;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
